// File: rtl/send_buffer_slot_mgt.sv
// send_buffer_slot_mgt: slot-chained retransmission buffer with free-slot FIFO, descriptor output and release walker
module send_buffer_slot_mgt #(
    parameter int SLOT_NUM_LOG = 8,
    parameter int DATA_W = 512,
    parameter int HEAD_W = 320,
    parameter int QPN_W = 24,
    parameter int PSN_W = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_insert_req_valid,
    input  logic [HEAD_W-1:0]       iv_insert_req_head,
    input  logic [DATA_W-1:0]       iv_insert_req_data,
    input  logic                    i_insert_req_start,
    input  logic                    i_insert_req_last,
    output logic                    o_insert_req_ready,
    output logic [SLOT_NUM_LOG-1:0] ov_available_slot_num,
    output logic                    o_desc_valid,
    output logic [SLOT_NUM_LOG-1:0] ov_desc_first_slot,
    output logic [SLOT_NUM_LOG:0]   ov_desc_slot_num,
    output logic [QPN_W-1:0]        ov_desc_qpn,
    output logic [PSN_W-1:0]        ov_desc_psn,
    input  logic                    i_desc_ready,
    input  logic                    i_release_valid,
    input  logic [SLOT_NUM_LOG-1:0] iv_release_first_slot,
    output logic                    o_release_ready,
    input  logic                    i_rd_en,
    input  logic [SLOT_NUM_LOG-1:0] iv_rd_slot,
    output logic [DATA_W-1:0]       ov_rd_data,
    output logic [SLOT_NUM_LOG-1:0] ov_rd_next_slot,
    output logic                    o_rd_last,
    output logic                    o_len_err
);
    localparam int N = 1 << SLOT_NUM_LOG;
    localparam int REQ_LSB = QPN_W + PSN_W;
    typedef enum logic [1:0] {INIT, IDLE, WRITE, DESC} ins_st_t;
    typedef enum logic {R_IDLE, R_WALK} rel_st_t;
    ins_st_t state, state_n;
    rel_st_t r_state, r_state_n;
    logic [SLOT_NUM_LOG-1:0] free_fifo [N];
    logic [DATA_W-1:0] slot_ram [N];
    logic [SLOT_NUM_LOG-1:0] next_tbl [N];
    logic [N-1:0] tail_tbl;
    logic [SLOT_NUM_LOG-1:0] init_idx, wr_ptr, rd_ptr, prev, cur, walk_cnt, pop_slot, push_slot;
    logic [SLOT_NUM_LOG:0] free_cnt, cnt_n;
    logic [31:0] slot_req, req_n;
    logic accept, pop, push, push_ok, walk_done, unused_head;

    assign o_insert_req_ready = (state == IDLE || state == WRITE) && free_cnt != '0;
    assign accept = i_insert_req_valid && o_insert_req_ready;
    assign o_release_ready = r_state == R_IDLE && state != INIT;
    assign pop_slot = free_fifo[rd_ptr];
    assign push_slot = state == INIT ? init_idx : cur;
    // A bogus double release must not overflow the free count
    assign push_ok = push && (!free_cnt[SLOT_NUM_LOG] || pop);
    // Walk length is bounded so a corrupted (cyclic) chain cannot hang the walker
    assign walk_done = tail_tbl[cur] || &walk_cnt;
    assign cnt_n = state == IDLE ? {{SLOT_NUM_LOG{1'b0}}, 1'b1} : ov_desc_slot_num + 1'b1;
    assign req_n = state == IDLE ? iv_insert_req_head[REQ_LSB +: 32] : slot_req;
    assign unused_head = ^iv_insert_req_head[HEAD_W-1:REQ_LSB+32];

    always_comb begin
        state_n = state;
        pop = 1'b0;
        o_desc_valid = 1'b0;
        case (state)
            INIT: state_n = &init_idx ? IDLE : INIT;
            IDLE: begin
                pop = accept && i_insert_req_start;
                if (pop) state_n = i_insert_req_last ? DESC : WRITE;
            end
            WRITE: begin
                pop = accept;
                if (accept && i_insert_req_last) state_n = DESC;
            end
            default: begin
                o_desc_valid = 1'b1;
                if (i_desc_ready) state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        push = state == INIT || r_state == R_WALK;
        r_state_n = r_state == R_IDLE ? (i_release_valid && o_release_ready ? R_WALK : R_IDLE)
                                      : (walk_done ? R_IDLE : R_WALK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            r_state <= R_IDLE;
        end else begin
            state <= state_n;
            r_state <= r_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_idx <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            free_cnt <= '0;
            prev <= '0;
            cur <= '0;
            walk_cnt <= '0;
            slot_req <= '0;
            ov_available_slot_num <= '0;
            ov_desc_first_slot <= '0;
            ov_desc_slot_num <= '0;
            ov_desc_qpn <= '0;
            ov_desc_psn <= '0;
            o_len_err <= 1'b0;
            ov_rd_data <= '0;
            ov_rd_next_slot <= '0;
            o_rd_last <= 1'b0;
        end else begin
            if (state == INIT) init_idx <= init_idx + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            free_cnt <= free_cnt + {{SLOT_NUM_LOG{1'b0}}, push_ok} - {{SLOT_NUM_LOG{1'b0}}, pop};
            ov_available_slot_num <= state == INIT ? '0 : free_cnt[SLOT_NUM_LOG] ? '1 : free_cnt[SLOT_NUM_LOG-1:0];
            if (pop) begin
                prev <= pop_slot;
                ov_desc_slot_num <= cnt_n;
                if (i_insert_req_last && 32'(cnt_n) != req_n) o_len_err <= 1'b1;
            end
            if (pop && state == IDLE) begin
                ov_desc_first_slot <= pop_slot;
                ov_desc_qpn <= iv_insert_req_head[QPN_W-1:0];
                ov_desc_psn <= iv_insert_req_head[QPN_W +: PSN_W];
                slot_req <= req_n;
            end
            cur <= r_state == R_IDLE ? iv_release_first_slot : next_tbl[cur];
            walk_cnt <= r_state == R_IDLE ? '0 : walk_cnt + 1'b1;
            if (i_rd_en) begin
                ov_rd_data <= slot_ram[iv_rd_slot];
                ov_rd_next_slot <= next_tbl[iv_rd_slot];
                o_rd_last <= tail_tbl[iv_rd_slot];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) free_fifo[wr_ptr] <= push_slot;
        if (rst_n && pop) begin
            slot_ram[pop_slot] <= iv_insert_req_data;
            if (state == WRITE) begin
                next_tbl[prev] <= pop_slot;
                tail_tbl[prev] <= 1'b0;
            end
            tail_tbl[pop_slot] <= i_insert_req_last;
        end
    end
endmodule

// File: tb/tb_send_buffer_slot_mgt.sv
// tb_send_buffer_slot_mgt: directed self-checking bench for send_buffer_slot_mgt
module tb_send_buffer_slot_mgt;
    logic clk = 1'b0, rst_n = 1'b0;
    logic i_insert_req_valid = 1'b0, i_insert_req_start = 1'b0, i_insert_req_last = 1'b0;
    logic [319:0] iv_insert_req_head = '0;
    logic [511:0] iv_insert_req_data = '0;
    logic o_insert_req_ready;
    logic [7:0] ov_available_slot_num;
    logic o_desc_valid;
    logic [7:0] ov_desc_first_slot;
    logic [8:0] ov_desc_slot_num;
    logic [23:0] ov_desc_qpn, ov_desc_psn;
    logic i_desc_ready = 1'b0, i_release_valid = 1'b0;
    logic [7:0] iv_release_first_slot = '0;
    logic o_release_ready;
    logic i_rd_en = 1'b0;
    logic [7:0] iv_rd_slot = '0;
    logic [511:0] ov_rd_data;
    logic [7:0] ov_rd_next_slot;
    logic o_rd_last, o_len_err;

    send_buffer_slot_mgt dut (
        .clk(clk), .rst_n(rst_n),
        .i_insert_req_valid(i_insert_req_valid), .iv_insert_req_head(iv_insert_req_head),
        .iv_insert_req_data(iv_insert_req_data), .i_insert_req_start(i_insert_req_start),
        .i_insert_req_last(i_insert_req_last), .o_insert_req_ready(o_insert_req_ready),
        .ov_available_slot_num(ov_available_slot_num), .o_desc_valid(o_desc_valid),
        .ov_desc_first_slot(ov_desc_first_slot), .ov_desc_slot_num(ov_desc_slot_num),
        .ov_desc_qpn(ov_desc_qpn), .ov_desc_psn(ov_desc_psn), .i_desc_ready(i_desc_ready),
        .i_release_valid(i_release_valid), .iv_release_first_slot(iv_release_first_slot),
        .o_release_ready(o_release_ready), .i_rd_en(i_rd_en), .iv_rd_slot(iv_rd_slot),
        .ov_rd_data(ov_rd_data), .ov_rd_next_slot(ov_rd_next_slot), .o_rd_last(o_rd_last),
        .o_len_err(o_len_err)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;

    typedef struct {
        logic [7:0]   slot;
        logic [511:0] data;
        logic [7:0]   nxt;
        logic         chk_nxt;
        logic         last;
    } rd_vec_t;
    rd_vec_t rv [5];

    function automatic logic [511:0] mk_data(input logic [31:0] t);
        return {16{t}};
    endfunction

    function automatic logic [319:0] mk_head(input logic [23:0] q, input logic [23:0] p, input logic [31:0] r);
        logic [319:0] h;
        h = '0;
        h[23:0] = q;
        h[47:24] = p;
        h[79:48] = r;
        return h;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic s, input logic l, input logic [319:0] h, input logic [511:0] d, output int n);
        n = 0;
        i_insert_req_valid = 1'b1;
        i_insert_req_start = s;
        i_insert_req_last = l;
        iv_insert_req_head = h;
        iv_insert_req_data = d;
        while (!o_insert_req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!o_insert_req_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_ready_timeout: got ready=0 after %0d cycles expected 1", n);
        end
        tick();
        i_insert_req_valid = 1'b0;
        i_insert_req_start = 1'b0;
        i_insert_req_last = 1'b0;
    endtask

    task automatic desc_ack();
        i_desc_ready = 1'b1;
        tick();
        i_desc_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [319:0] h1, h2, h3, ha, hb;
        int n;
        rv[0] = '{8'd0, mk_data(32'hA0), 8'd1, 1'b1, 1'b0};
        rv[1] = '{8'd1, mk_data(32'hA1), 8'd2, 1'b1, 1'b0};
        rv[2] = '{8'd2, mk_data(32'hA2), 8'd0, 1'b0, 1'b1};
        rv[3] = '{8'd3, mk_data(32'hB0), 8'd4, 1'b1, 1'b0};
        rv[4] = '{8'd4, mk_data(32'hB1), 8'd0, 1'b0, 1'b1};
        h1 = mk_head(24'h12, 24'h100, 32'd3);
        h2 = mk_head(24'h34, 24'h200, 32'd2);
        h3 = mk_head(24'h56, 24'h300, 32'd4);
        ha = mk_head(24'h77, 24'h400, 32'd4);
        hb = mk_head(24'h88, 24'h500, 32'd253);

        repeat (3) tick();
        chk("rst_avail", ov_available_slot_num, 0);
        chk("rst_ready", o_insert_req_ready, 0);
        chk("rst_desc_valid", o_desc_valid, 0);
        chk("rst_rel_ready", o_release_ready, 0);
        chk("rst_len_err", o_len_err, 0);
        chk("rst_rd_data", ov_rd_data, 0);
        rst_n = 1'b1;
        repeat (255) tick();
        chk("init_ready", o_insert_req_ready, 0);
        chk("init_avail", ov_available_slot_num, 0);
        chk("init_rel_ready", o_release_ready, 0);
        repeat (2) tick();
        chk("post_init_avail", ov_available_slot_num, 255);
        chk("post_init_ready", o_insert_req_ready, 1);
        chk("post_init_rel_ready", o_release_ready, 1);

        beat(1'b1, 1'b0, h1, mk_data(32'hA0), n);
        beat(1'b0, 1'b0, h1, mk_data(32'hA1), n);
        beat(1'b0, 1'b1, h1, mk_data(32'hA2), n);
        chk("p1_desc_valid", o_desc_valid, 1);
        chk("p1_first", ov_desc_first_slot, 0);
        chk("p1_num", ov_desc_slot_num, 3);
        chk("p1_qpn", ov_desc_qpn, 24'h12);
        chk("p1_psn", ov_desc_psn, 24'h100);

        i_insert_req_valid = 1'b1;
        i_insert_req_start = 1'b1;
        iv_insert_req_head = h2;
        iv_insert_req_data = mk_data(32'hB0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_desc_valid", o_desc_valid, 1);
            chk("hold_first", ov_desc_first_slot, 0);
            chk("hold_num", ov_desc_slot_num, 3);
            chk("hold_ready", o_insert_req_ready, 0);
        end
        chk("p1_avail", ov_available_slot_num, 253);
        chk("p1_len_err", o_len_err, 0);
        desc_ack();
        chk("ack_desc_valid", o_desc_valid, 0);

        i_release_valid = 1'b1;
        iv_release_first_slot = 8'd0;
        beat(1'b1, 1'b0, h2, mk_data(32'hB0), n);
        i_release_valid = 1'b0;
        beat(1'b0, 1'b1, h2, mk_data(32'hB1), n);
        chk("p2_first", ov_desc_first_slot, 3);
        chk("p2_num", ov_desc_slot_num, 2);
        chk("p2_qpn", ov_desc_qpn, 24'h34);
        chk("p2_psn", ov_desc_psn, 24'h200);
        repeat (4) tick();
        chk("p2_avail", ov_available_slot_num, 254);
        chk("p2_rel_ready", o_release_ready, 1);
        desc_ack();

        for (int i = 0; i < 5; i++) begin
            i_rd_en = 1'b1;
            iv_rd_slot = rv[i].slot;
            tick();
            i_rd_en = 1'b0;
            chk($sformatf("rd%0d_data", i), ov_rd_data, rv[i].data);
            if (rv[i].chk_nxt) chk($sformatf("rd%0d_next", i), ov_rd_next_slot, rv[i].nxt);
            chk($sformatf("rd%0d_last", i), o_rd_last, rv[i].last);
        end
        iv_rd_slot = 8'd0;
        tick();
        chk("rd_hold_data", ov_rd_data, mk_data(32'hB1));

        beat(1'b1, 1'b0, h3, mk_data(32'hC0), n);
        beat(1'b0, 1'b1, h3, mk_data(32'hC1), n);
        chk("le_len_err", o_len_err, 1);
        chk("le_num", ov_desc_slot_num, 2);
        chk("le_first", ov_desc_first_slot, 5);
        desc_ack();
        repeat (3) tick();
        chk("le_sticky", o_len_err, 1);

        beat(1'b1, 1'b0, h3, mk_data(32'hC0), n);
        rst_n = 1'b0;
        repeat (2) tick();
        chk("mid_rst_avail", ov_available_slot_num, 0);
        chk("mid_rst_len_err", o_len_err, 0);
        chk("mid_rst_ready", o_insert_req_ready, 0);
        chk("mid_rst_rel_ready", o_release_ready, 0);
        rst_n = 1'b1;
        repeat (257) tick();
        chk("reinit_avail", ov_available_slot_num, 255);

        for (int k = 0; k < 4; k++) beat(k == 0, k == 3, ha, mk_data(32'hD0 + 32'(k)), n);
        chk("pa_first", ov_desc_first_slot, 0);
        chk("pa_num", ov_desc_slot_num, 4);
        desc_ack();
        for (int k = 0; k < 252; k++) beat(k == 0, 1'b0, hb, mk_data(32'h1000 + 32'(k)), n);
        i_insert_req_valid = 1'b1;
        i_insert_req_last = 1'b1;
        iv_insert_req_data = mk_data(32'h1000 + 32'd252);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_stall_ready", o_insert_req_ready, 0);
        end
        chk("full_avail", ov_available_slot_num, 0);
        i_release_valid = 1'b1;
        iv_release_first_slot = 8'd0;
        tick();
        i_release_valid = 1'b0;
        beat(1'b0, 1'b1, hb, mk_data(32'h1000 + 32'd252), n);
        chk("full_release_within_2", n <= 2, 1);
        chk("pb_desc_valid", o_desc_valid, 1);
        chk("pb_first", ov_desc_first_slot, 4);
        chk("pb_num", ov_desc_slot_num, 253);
        chk("pb_qpn", ov_desc_qpn, 24'h88);
        chk("pb_len_err", o_len_err, 0);
        i_rd_en = 1'b1;
        iv_rd_slot = 8'd255;
        tick();
        chk("pb_rd255_data", ov_rd_data, mk_data(32'h1000 + 32'd251));
        chk("pb_rd255_next", ov_rd_next_slot, 0);
        chk("pb_rd255_last", o_rd_last, 0);
        iv_rd_slot = 8'd0;
        tick();
        i_rd_en = 1'b0;
        chk("pb_rd0_data", ov_rd_data, mk_data(32'h1000 + 32'd252));
        chk("pb_rd0_last", o_rd_last, 1);
        desc_ack();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
